n64_pi_host: RTL

// - Initiator (console) end of the N64 Parallel Interface: drives ALEH/ALEL/READ/WRITE and the AD16 bus.
// - Executes word bursts requested by an internal master.
// - Used as a bench/bring-up PI driver for the cartridge-side PI target.
// - Also serves as the PI port for the passthrough/flash-programmer path.
// - Each 32-bit word is transferred as two 16-bit halfwords; halfword 0 = data[31:16].
// - Bursts crossing a 512-byte PI page are split automatically by re-issuing the address phases.

---
 rtl/n64_pi_pkg.sv | 29 ++
 rtl/n64_pi_host_timer.sv | 24 ++
 rtl/n64_pi_host.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/n64_pi_pkg.sv
// Shared N64 Parallel Interface definitions: ALE mode encodings, host FSM states and page geometry.
package n64_pi_pkg;

    // {ALEH, ALEL} bus modes, common to host and target
    localparam logic [1:0] PI_MODE_IDLE  = 2'b10;
    localparam logic [1:0] PI_MODE_HIGH  = 2'b11;
    localparam logic [1:0] PI_MODE_LOW   = 2'b01;
    localparam logic [1:0] PI_MODE_VALID = 2'b00;

    localparam int unsigned PI_PAGE_BYTES = 512;
    localparam int unsigned PI_PAGE_BITS  = $clog2(PI_PAGE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_H = 3'd1,
        ST_ADDR_L = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FETCH  = 3'd4,
        ST_PULSE  = 3'd5,
        ST_GAP    = 3'd6,
        ST_DONE   = 3'd7
    } pi_host_state_t;

    // True when the address sits on the first byte of a PI page
    function automatic logic page_start(input logic [31:0] addr);
        return addr[PI_PAGE_BITS-1:0] == '0;
    endfunction

endpackage

// File: rtl/n64_pi_host_timer.sv
// Loadable 4-bit down-counter; terminal is high while the count sits at zero.
module n64_pi_host_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic       terminal
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign terminal = (count_reg == 4'd0);

endmodule

// File: rtl/n64_pi_host.sv
// Console-side PI initiator: runs word bursts as ALE address phases followed by halfword strobes,
// re-issuing the address phases whenever a burst crosses into a new 512-byte page.
module n64_pi_host
    import n64_pi_pkg::*;
#(
    parameter int unsigned T_ALE   = 4,
    parameter int unsigned T_PULSE = 6,
    parameter int unsigned T_GAP   = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_request,
    input  logic        i_write,
    input  logic [31:0] i_address,
    input  logic [7:0]  i_length,
    output logic        o_busy,
    output logic        o_done,
    input  logic [31:0] i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_aleh,
    output logic        o_alel,
    output logic        o_read,
    output logic        o_write,
    output logic [15:0] o_ad_out,
    output logic        o_ad_oe,
    input  logic [15:0] i_ad_in
);

    // Timer counts down to zero, so each phase loads its length minus one
    localparam logic [3:0] ALE_LOAD   = 4'(T_ALE - 1);
    localparam logic [3:0] PULSE_LOAD = 4'(T_PULSE - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(T_GAP - 1);

    pi_host_state_t state_reg, state_next;
    logic        write_reg;
    logic [31:0] addr_reg;
    logic [8:0]  words_reg;
    logic        hw_reg;
    logic [31:0] word_reg;
    logic [15:0] rd_hi_reg;
    logic [31:0] rd_data_reg;
    logic        rd_valid_reg;
    logic        timer_load;
    logic [3:0]  timer_value;
    logic        timer_done;

    n64_pi_host_timer u_timer (
        .clk        (i_clk),
        .reset_n    (i_reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .terminal   (timer_done)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (i_request) state_next = ST_ADDR_H;
            ST_ADDR_H: if (timer_done) state_next = ST_ADDR_L;
            ST_ADDR_L: if (timer_done) state_next = ST_SETTLE;
            ST_SETTLE: if (timer_done) state_next = (write_reg && !hw_reg) ? ST_FETCH : ST_PULSE;
            ST_FETCH:  if (i_wr_valid) state_next = ST_PULSE;
            ST_PULSE:  if (timer_done) state_next = ST_GAP;
            ST_GAP: begin
                // hw_reg has already toggled, so hw_reg==0 here means a word just completed
                if (timer_done) begin
                    if (words_reg == 9'd0)
                        state_next = ST_DONE;
                    else if (!hw_reg && page_start(addr_reg))
                        state_next = ST_ADDR_H;
                    else if (write_reg && !hw_reg)
                        state_next = ST_FETCH;
                    else
                        state_next = ST_PULSE;
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_load  = (state_next != state_reg);
        timer_value = 4'd0;
        case (state_next)
            ST_ADDR_H, ST_ADDR_L, ST_SETTLE: timer_value = ALE_LOAD;
            ST_PULSE:                        timer_value = PULSE_LOAD;
            ST_GAP:                          timer_value = GAP_LOAD;
            default:                         timer_value = 4'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            write_reg    <= 1'b0;
            addr_reg     <= 32'd0;
            words_reg    <= 9'd0;
            hw_reg       <= 1'b0;
            word_reg     <= 32'd0;
            rd_hi_reg    <= 16'd0;
            rd_data_reg  <= 32'd0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_request) begin
                        write_reg <= i_write;
                        addr_reg  <= i_address & ~32'd3;
                        words_reg <= {1'b0, i_length} + 9'd1;
                        hw_reg    <= 1'b0;
                    end
                end
                ST_ADDR_H: hw_reg <= 1'b0;
                ST_FETCH:  if (i_wr_valid) word_reg <= i_wr_data;
                ST_PULSE: begin
                    if (timer_done) begin
                        hw_reg <= !hw_reg;
                        if (!write_reg) begin
                            if (!hw_reg) begin
                                rd_hi_reg <= i_ad_in;
                            end else begin
                                rd_data_reg  <= {rd_hi_reg, i_ad_in};
                                rd_valid_reg <= 1'b1;
                            end
                        end
                        if (hw_reg) begin
                            addr_reg  <= addr_reg + 32'd4;
                            words_reg <= words_reg - 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        {o_aleh, o_alel} = PI_MODE_IDLE;
        o_read   = 1'b1;
        o_write  = 1'b1;
        o_ad_oe  = 1'b0;
        o_ad_out = 16'd0;
        case (state_reg)
            ST_ADDR_H: begin
                {o_aleh, o_alel} = PI_MODE_HIGH;
                o_ad_oe  = 1'b1;
                o_ad_out = addr_reg[31:16];
            end
            ST_ADDR_L: begin
                {o_aleh, o_alel} = PI_MODE_LOW;
                o_ad_oe  = 1'b1;
                o_ad_out = addr_reg[15:0];
            end
            ST_SETTLE, ST_FETCH, ST_PULSE, ST_GAP: begin
                {o_aleh, o_alel} = PI_MODE_VALID;
                o_ad_oe  = write_reg;
                o_ad_out = write_reg ? (hw_reg ? word_reg[15:0] : word_reg[31:16]) : 16'd0;
                if (state_reg == ST_PULSE) begin
                    o_read  = write_reg;
                    o_write = !write_reg;
                end
            end
            default: ;
        endcase
    end

    assign o_busy     = (state_reg != ST_IDLE);
    assign o_done     = (state_reg == ST_DONE);
    assign o_wr_ready = (state_reg == ST_FETCH);
    assign o_rd_data  = rd_data_reg;
    assign o_rd_valid = rd_valid_reg;

endmodule
